gf_div2_iter: RTL and testbench

- Iterative GF(2^8) divide-by-2^k unit over the field polynomial z^8+z^4+z^3+z^2+1 (9'h11D).
- It is the exact inverse of the existing multiply-by-2 (xtime) path: each step halves the operand in the field.
- The CLEFIA datapath and its test harness use it to undo chains of xtime operations, and to generate inverse-direction constants at run time.
- Valid/ready on both sides; one operation in flight at a time.

---
 rtl/gf_pkg.sv | 23 ++
 rtl/gf_div2_step.sv | 14 +
 rtl/gf_div2_iter.sv | 101 ++++++++++
 tb/tb_gf_div2_iter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the divide-by-2^k datapath: field constants,
// controller state encoding and the single-step halving function.
package gf_pkg;

    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam logic [7:0] GF_HMASK = GF_POLY[8:1];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Inverse of xtime: drop the low bit, folding the reduction back in when it was set.
    function automatic logic [7:0] gf_half_m(input logic [7:0] x, input logic [7:0] hmask);
        return (x >> 1) ^ (x[0] ? hmask : 8'h00);
    endfunction

    function automatic logic [7:0] gf_half(input logic [7:0] x);
        return gf_half_m(x, GF_HMASK);
    endfunction

endpackage

// File: rtl/gf_div2_step.sv
// One combinational GF(2^8) halving stage; passes the operand through when disabled.
module gf_div2_step
    import gf_pkg::*;
#(
    parameter logic [7:0] HMASK = GF_HMASK
) (
    input  logic       en,
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = en ? gf_half_m(x, HMASK) : x;

endmodule

// File: rtl/gf_div2_iter.sv
// Iterative GF(2^8) a * 2^-k, SPC halvings per clock; one request in flight,
// result held in DONE until out_ready.
module gf_div2_iter
    import gf_pkg::*;
#(
    parameter logic [8:0] POLY = GF_POLY,
    parameter int         K_W  = 8,
    parameter int         SPC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     din,
    input  logic [K_W-1:0] k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     dout,
    output logic           busy
);

    localparam logic [7:0] HMASK = POLY[8:1];

    if (!(SPC == 1 || SPC == 2 || SPC == 4)) begin : g_bad_spc
        $error("gf_div2_iter: SPC must be 1, 2 or 4");
    end

    state_t         state;
    logic [7:0]     acc;
    logic [K_W-1:0] cnt;
    logic [K_W-1:0] n_step;
    logic [K_W-1:0] cnt_next;
    logic [7:0]     chain [0:SPC];

    // Stage i only fires while i < cnt, so the last clock applies exactly cnt steps.
    assign chain[0] = acc;
    for (genvar gi = 0; gi < SPC; gi++) begin : g_stage
        gf_div2_step #(.HMASK(HMASK)) u_step (
            .en (cnt > K_W'(gi)),
            .x  (chain[gi]),
            .y  (chain[gi+1])
        );
    end

    assign n_step   = (cnt < K_W'(SPC)) ? cnt : K_W'(SPC);
    assign cnt_next = cnt - n_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= din;
                        cnt      <= k;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (k == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            dout      <= din;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= chain[SPC];
                    cnt <= cnt_next;
                    if (cnt_next == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        dout      <= chain[SPC];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_div2_iter.sv
// Scoreboard bench for gf_div2_iter: SPC=1 instance under random traffic and
// backpressure, plus an SPC=4 instance for multi-step latency and results.
module tb_gf_div2_iter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] din = 8'h00;
    logic [7:0] k = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] dout;
    logic       busy;

    logic       in4_valid = 1'b0;
    logic       in4_ready;
    logic [7:0] din4 = 8'h00;
    logic [7:0] k4 = 8'h00;
    logic       out4_valid;
    logic [7:0] dout4;
    logic       busy4;

    always #5 clk = ~clk;

    gf_div2_iter #(.POLY(9'h11D), .K_W(8), .SPC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .k(k), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy)
    );

    gf_div2_iter #(.POLY(9'h11D), .K_W(8), .SPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready),
        .din(din4), .k(k4), .out_valid(out4_valid), .out_ready(1'b1),
        .dout(dout4), .busy(busy4)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] kk;
        logic [7:0] exp;
        int         acc_cyc;
    } txn_t;

    txn_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;
    bit   prev_ov = 1'b0;

    // Reference: plain field multiply, and a * (2^-1)^k by square-and-multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_div(input logic [7:0] a, input int kk);
        logic [7:0] r = a, base = 8'h8E;
        int e = kk;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return gmul(x, 8'h02);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    // Monitor: latency on each rising out_valid, data + round trip on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    check("latency", cyc - sbq[0].acc_cyc, int'(sbq[0].kk) + 1);
                end
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                txn_t t;
                logic [7:0] x;
                t = sbq.pop_front();
                check("dout", dout, t.exp);
                x = dout;
                for (int i = 0; i < int'(t.kk); i++) x = xt(x);
                check("round_trip", x, t.d);
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] kk,
                        input logic [7:0] exp, input bit track);
        int w = 0;
        txn_t t;
        @(negedge clk);
        in_valid = 1'b1;
        din = d;
        k = kk;
        while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        t.d = d; t.kk = kk; t.exp = exp; t.acc_cyc = cyc;
        if (track) sbq.push_back(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic run4(input logic [7:0] d, input logic [7:0] kk);
        int c, w = 0;
        @(negedge clk);
        check("spc4_in_ready", in4_ready, 1);
        in4_valid = 1'b1;
        din4 = d;
        k4 = kk;
        c = cyc;
        @(posedge clk);
        #1;
        in4_valid = 1'b0;
        @(negedge clk);
        while (!out4_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("spc4_latency", cyc - c, (int'(kk) + 3) / 4 + 1);
        check("spc4_dout", dout4, ref_div(d, int'(kk)));
    endtask

    initial begin
        logic [7:0] d, kk;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        send(8'h01, 8'd1, 8'h8E, 1);
        send(8'h1D, 8'd1, 8'h80, 1);
        send(8'h01, 8'd2, 8'h47, 1);
        send(8'h02, 8'd1, 8'h01, 1);
        send(8'h00, 8'd37, 8'h00, 1);
        d = 8'($urandom);
        send(d, 8'd255, d, 1);
        drain();

        // k=0 with a stalled consumer: result must hold and new requests are ignored.
        rdy_force = 1'b0;
        send(8'hA5, 8'd0, 8'hA5, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            din = 8'h5A;
            k = 8'd3;
            check("hold_out_valid", out_valid, 1);
            check("hold_dout", dout, 8'hA5);
            check("hold_in_ready", in_ready, 0);
            check("hold_busy", busy, 1);
        end
        in_valid = 1'b0;
        rdy_force = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        check("post_hold_idle_busy", busy, 0);

        // Reset in the middle of a long operation.
        send(8'h33, 8'd50, 8'h00, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_dout", dout, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h01, 8'd1, 8'h8E, 1);
        drain();

        // Random traffic with random consumer backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom);
            kk = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            send(d, kk, ref_div(d, int'(kk)), 1);
        end
        drain();
        rdy_rand = 1'b0;
        rdy_force = 1'b1;

        run4(8'($urandom), 8'd255);
        run4(8'($urandom), 8'd0);
        run4(8'($urandom), 8'd1);
        run4(8'($urandom), 8'd3);
        run4(8'($urandom), 8'd4);
        run4(8'($urandom), 8'd5);
        run4(8'h00, 8'd37);
        for (int i = 0; i < 10; i++) run4(8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
